// File: rtl/gray_seq_pkg.sv
// Shared types and constants for the Gray-code sequencer.
package gray_seq_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} gs_state_t;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/gray_seq_ctrl_if.sv
// Control plus output stream bundle of the Gray-code sequencer.
interface gray_seq_ctrl_if #(
    parameter int unsigned WIDTH = 4
);
    logic             start;
    logic             abort;
    logic [WIDTH-1:0] start_val;
    logic [WIDTH-1:0] end_val;
    logic             dir;
    logic             loop;
    logic             out_ready;
    logic             out_valid;
    logic [WIDTH-1:0] gray_out;
    logic [WIDTH-1:0] bin_out;
    logic             busy;
    logic             done;
    logic             seq_err;

    modport master (
        output start, abort, start_val, end_val, dir, loop, out_ready,
        input  out_valid, gray_out, bin_out, busy, done, seq_err
    );

    modport slave (
        input  start, abort, start_val, end_val, dir, loop, out_ready,
        output out_valid, gray_out, bin_out, busy, done, seq_err
    );

endinterface

// File: rtl/bin_to_gray_conv.sv
// Purely combinational binary-to-Gray converter.
module bin_to_gray_conv #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_bin,
    output logic [WIDTH-1:0] o_gray
);

    assign o_gray = i_bin ^ (i_bin >> 1);

endmodule

// File: rtl/gray_seq_ctrl.sv
// Start/end binary sequencer feeding a Gray converter onto a valid/ready stream.
// Optional Hamming-distance checker is enabled by defining GRAY_SEQ_CHECK_EN.
module gray_seq_ctrl
    import gray_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    gray_seq_ctrl_if.slave  bus
);

    localparam logic [WIDTH-1:0] BIN_ONE = WIDTH'(1);

    gs_state_t        r_state;
    gs_state_t        w_state_nxt;
    logic [WIDTH-1:0] r_bin;
    logic [WIDTH-1:0] r_start;
    logic [WIDTH-1:0] r_end;
    logic             r_dir;
    logic             r_loop;
    logic             w_accept;
    logic             w_beat;
    logic             w_at_end;
    logic [WIDTH-1:0] w_bin_step;
    logic [WIDTH-1:0] w_gray;

    assign w_accept   = (r_state == ST_IDLE) & bus.start & ~bus.abort;
    assign w_beat     = (r_state == ST_RUN) & bus.out_ready;
    assign w_at_end   = (r_bin == r_end);
    assign w_bin_step = (r_dir == DIR_DOWN) ? (r_bin - BIN_ONE) : (r_bin + BIN_ONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_nxt = ST_RUN;
            ST_RUN: begin
                if (bus.abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_beat && w_at_end && !r_loop) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.out_valid = (r_state == ST_RUN);
        bus.busy      = (r_state == ST_RUN) || (r_state == ST_DONE);
        bus.done      = (r_state == ST_DONE);
    end

    // Config is captured once per start; an aborted beat leaves the count untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bin   <= '0;
            r_start <= '0;
            r_end   <= '0;
            r_dir   <= DIR_UP;
            r_loop  <= 1'b0;
        end else if (w_accept) begin
            r_bin   <= bus.start_val;
            r_start <= bus.start_val;
            r_end   <= bus.end_val;
            r_dir   <= bus.dir;
            r_loop  <= bus.loop;
        end else if (w_beat && !bus.abort) begin
            if (!w_at_end) begin
                r_bin <= w_bin_step;
            end else if (r_loop) begin
                r_bin <= r_start;
            end
        end
    end

    bin_to_gray_conv #(
        .WIDTH (WIDTH)
    ) u_conv (
        .i_bin  (r_bin),
        .o_gray (w_gray)
    );

    assign bus.bin_out  = r_bin;
    assign bus.gray_out = w_gray;

`ifdef GRAY_SEQ_CHECK_EN
    logic             r_seq_err;
    logic [WIDTH-1:0] w_gray_step;

    assign w_gray_step = w_bin_step ^ (w_bin_step >> 1);

    // Only plain steps are checked; reloads to start_val may legally jump several bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_seq_err <= 1'b0;
        end else if (w_accept) begin
            r_seq_err <= 1'b0;
        end else if (w_beat && !bus.abort && !w_at_end &&
                     ($countones(w_gray ^ w_gray_step) != 1)) begin
            r_seq_err <= 1'b1;
        end
    end

    assign bus.seq_err = r_seq_err;
`else
    assign bus.seq_err = 1'b0;
`endif

endmodule
